// File: rtl/prime_stream_gen.sv
// prime_stream_gen: emits the first n primes at or above a over a valid/ready stream.
// Primality is decided by sequential trial division using a restoring shift-subtract remainder unit.
module prime_stream_gen #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic [W-1:0] prime,
  output logic         prime_valid,
  input  logic         prime_ready,
  output logic         prime_last,
  output logic         done,
  output logic         ovf
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DIV   = 3'd2,
    EVAL  = 3'd3,
    EMIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t         state_r, state_s;
  logic [W-1:0]   cand_r, target_r, cnt_r, d_r, rem_r, dvd_r, prime_r;
  logic [2*W-1:0] sq_r;
  logic [CW-1:0]  bit_r;
  logic           busy_r, valid_r, last_r, done_r, ovf_r;

  logic           cand_max_s, xfer_s, step_s;
  logic [2*W-1:0] sq_step_s;
  logic [W:0]     shift_s, diff_s;
  logic [W-1:0]   rem_next_s;

  // Datapath helpers: next sq = sq + 2d + 1, and one restoring-division step.
  always_comb begin
    cand_max_s = (cand_r == {W{1'b1}});
    xfer_s     = valid_r && prime_ready;
    sq_step_s  = sq_r + {{(W-1){1'b0}}, d_r, 1'b1};
    shift_s    = {rem_r, dvd_r[W-1]};
    diff_s     = shift_s - {1'b0, d_r};
    if (shift_s >= {1'b0, d_r}) begin
      rem_next_s = diff_s[W-1:0];
    end else begin
      rem_next_s = shift_s[W-1:0];
    end
  end

  // Next-state logic; step_s marks moving on to the following candidate.
  always_comb begin
    state_s = state_r;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (n == {W{1'b0}}) ? DONE : CHECK;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (cand_r < W'(2)) begin
          step_s = 1'b1;
        end else if (cand_r < W'(4)) begin
          state_s = EMIT;
        end else begin
          state_s = DIV;
        end
      end
      DIV: begin
        state_s = (bit_r == CW'(W - 1)) ? EVAL : DIV;
      end
      EVAL: begin
        if (rem_r == {W{1'b0}}) begin
          step_s = 1'b1;
        end else if (sq_step_s > {{W{1'b0}}, cand_r}) begin
          state_s = EMIT;
        end else begin
          state_s = DIV;
        end
      end
      EMIT: begin
        if (xfer_s && last_r) begin
          state_s = DONE;
        end else if (xfer_s) begin
          step_s = 1'b1;
        end else begin
          state_s = EMIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (step_s) begin
      state_s = cand_max_s ? DONE : CHECK;
    end else begin
      state_s = state_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Job registers, divider and registered stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_r   <= {W{1'b0}};
      target_r <= {W{1'b0}};
      cnt_r    <= {W{1'b0}};
      d_r      <= {W{1'b0}};
      rem_r    <= {W{1'b0}};
      dvd_r    <= {W{1'b0}};
      sq_r     <= {(2*W){1'b0}};
      bit_r    <= {CW{1'b0}};
      prime_r  <= {W{1'b0}};
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cand_r   <= a;
            target_r <= n;
            cnt_r    <= {W{1'b0}};
            ovf_r    <= 1'b0;
            busy_r   <= 1'b1;
          end
        end
        CHECK: begin
          d_r   <= W'(2);
          sq_r  <= (2*W)'(4);
          rem_r <= {W{1'b0}};
          dvd_r <= cand_r;
          bit_r <= {CW{1'b0}};
        end
        DIV: begin
          rem_r <= rem_next_s;
          dvd_r <= dvd_r << 1;
          bit_r <= bit_r + CW'(1);
        end
        EVAL: begin
          sq_r  <= sq_step_s;
          d_r   <= d_r + W'(1);
          rem_r <= {W{1'b0}};
          dvd_r <= cand_r;
          bit_r <= {CW{1'b0}};
        end
        EMIT: begin
          if (xfer_s) begin
            cnt_r   <= cnt_r + W'(1);
            valid_r <= 1'b0;
            last_r  <= 1'b0;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
      if (step_s && cand_max_s) begin
        ovf_r <= 1'b1;
      end else if (step_s) begin
        cand_r <= cand_r + W'(1);
      end
      // prime and prime_last are loaded only on EMIT entry, so they hold under backpressure.
      if (state_s == EMIT && state_r != EMIT) begin
        valid_r <= 1'b1;
        prime_r <= cand_r;
        last_r  <= (cnt_r == target_r - W'(1));
      end
      done_r <= (state_r == DONE);
    end
  end

  assign busy        = busy_r;
  assign prime       = prime_r;
  assign prime_valid = valid_r;
  assign prime_last  = last_r;
  assign done        = done_r;
  assign ovf         = ovf_r;

endmodule
